// File: rtl/bluetile_pkg.sv
// bluetile_pkg: shared flit geometry, header field helpers and FSM state types
package bluetile_pkg;
    localparam int FLIT_W = 32;
    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 4;
    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
    localparam int MAX_PAYLOAD = 31;
    typedef enum logic {IN_HDR, IN_PAY} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_PAY} out_state_t;
    function automatic logic [LEN_W-1:0] hdr_len(input logic [FLIT_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction
endpackage

// File: rtl/bluetile_word_ram.sv
// bluetile_word_ram: DEPTH x FLIT_W RAM, synchronous write, asynchronous read
module bluetile_word_ram
    import bluetile_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [FLIT_W-1:0] wd,
    input  logic [AW-1:0]     ra,
    output logic [FLIT_W-1:0] rd
);
    logic [FLIT_W-1:0] mem [DEPTH];
    // write port
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    assign rd = mem[ra];
endmodule

// File: rtl/bluetile_packet_buffer.sv
// bluetile_packet_buffer: store-and-forward buffer releasing only whole packets to the network
module bluetile_packet_buffer
    import bluetile_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [FLIT_W-1:0] in_DIN,
    input  logic              in_valid,
    output logic              in_accept,
    output logic [FLIT_W-1:0] out_DOUT,
    output logic              out_valid,
    input  logic              out_accept,
    output logic [5:0]        pkt_ready,
    output logic              len_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    in_state_t        in_st, in_st_d;
    out_state_t       out_st, out_st_d;
    logic [PW-1:0]    wr_ptr, rd_ptr, count, complete;
    logic [LEN_W-1:0] in_rem, in_rem_d, out_rem, out_rem_d, in_len, out_len;
    logic             in_fire, out_fire, in_done, hdr_pop, len_bad;
    logic [FLIT_W-1:0] rd_data;
    bluetile_word_ram #(.DEPTH(DEPTH)) u_ram (
        .clk(CLK),
        .we (in_fire),
        .wa (wr_ptr[AW-1:0]),
        .wd (in_DIN),
        .ra (rd_ptr[AW-1:0]),
        .rd (rd_data)
    );
    assign count     = wr_ptr - rd_ptr;
    assign in_accept = count != PW'(DEPTH);
    assign in_fire   = in_valid && in_accept;
    assign out_valid = out_st == OUT_PAY || complete != '0;
    assign out_fire  = out_valid && out_accept;
    assign out_DOUT  = rd_data;
    assign in_len    = hdr_len(in_DIN);
    assign out_len   = hdr_len(rd_data);
    assign len_bad   = in_fire && in_st == IN_HDR && {1'b0, in_len} > (LEN_W + 1)'(MAX_PAYLOAD);
    assign pkt_ready = complete > PW'(63) ? 6'd63 : complete[5:0];
    // input side: follow header length to spot the last flit of each packet
    always_comb begin
        in_st_d  = in_st;
        in_rem_d = in_rem;
        in_done  = 1'b0;
        if (in_fire) begin
            if (in_st == IN_HDR) begin
                in_rem_d = in_len;
                in_done  = in_len == '0;
                in_st_d  = in_len == '0 ? IN_HDR : IN_PAY;
            end else begin
                in_rem_d = in_rem - 1'b1;
                in_done  = in_rem == LEN_W'(1);
                in_st_d  = in_rem == LEN_W'(1) ? IN_HDR : IN_PAY;
            end
        end
    end
    // output side: a header pop claims one complete packet, payload follows unconditionally
    always_comb begin
        out_st_d  = out_st;
        out_rem_d = out_rem;
        hdr_pop   = 1'b0;
        if (out_fire) begin
            if (out_st == OUT_IDLE) begin
                hdr_pop   = 1'b1;
                out_rem_d = out_len;
                out_st_d  = out_len == '0 ? OUT_IDLE : OUT_PAY;
            end else begin
                out_rem_d = out_rem - 1'b1;
                out_st_d  = out_rem == LEN_W'(1) ? OUT_IDLE : OUT_PAY;
            end
        end
    end
    // state, pointers and packet counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_st    <= IN_HDR;
            out_st   <= OUT_IDLE;
            in_rem   <= '0;
            out_rem  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            complete <= '0;
            len_err  <= 1'b0;
        end else begin
            in_st    <= in_st_d;
            out_st   <= out_st_d;
            in_rem   <= in_rem_d;
            out_rem  <= out_rem_d;
            wr_ptr   <= wr_ptr + PW'(in_fire);
            rd_ptr   <= rd_ptr + PW'(out_fire);
            complete <= complete + PW'(in_done) - PW'(hdr_pop);
            len_err  <= len_err || len_bad;
        end
    end
endmodule

// File: tb/tb_bluetile_packet_buffer.sv
// tb_bluetile_packet_buffer: randomized packet traffic against a packet-level queue model
module tb_bluetile_packet_buffer;
    localparam int DEPTH = 64;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_din = '0;
    logic        in_valid = 1'b0;
    logic        in_accept;
    logic [31:0] out_dout;
    logic        out_valid;
    logic        out_accept = 1'b0;
    logic [5:0]  pkt_ready;
    logic        len_err;
    int checks = 0;
    int errors = 0;
    logic [31:0] src_q[$];
    int          src_sz[$];
    logic [31:0] held[$];
    int          sizes[$];
    int          ready = 0;
    int          out_left = 0;

    bluetile_packet_buffer #(.DEPTH(DEPTH)) dut (
        .CLK(clk),
        .RST(rst),
        .in_DIN(in_din),
        .in_valid(in_valid),
        .in_accept(in_accept),
        .out_DOUT(out_dout),
        .out_valid(out_valid),
        .out_accept(out_accept),
        .pkt_ready(pkt_ready),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add_pkt(input logic [31:0] hdr);
        int n;
        n = int'(hdr[4:0]);
        src_q.push_back(hdr);
        src_sz.push_back(n == 0 ? 1 : 0);
        for (int i = 1; i <= n; i++) begin
            src_q.push_back($urandom);
            src_sz.push_back(i == n ? n + 1 : 0);
        end
    endtask

    task automatic step(input int pv, input int pa);
        bit iv, oa, exp_acc, exp_ov;
        int sz;
        @(negedge clk);
        iv = src_q.size() > 0 && $urandom_range(99) < pv;
        oa = $urandom_range(99) < pa;
        in_valid = iv;
        in_din = iv ? src_q[0] : $urandom;
        out_accept = oa;
        #1;
        exp_acc = held.size() < DEPTH;
        exp_ov = ready > 0 || out_left > 0;
        check("in_accept", in_accept, exp_acc);
        check("out_valid", out_valid, exp_ov);
        check("pkt_ready", pkt_ready, ready > 63 ? 63 : ready);
        check("len_err", len_err, 0);
        if (exp_ov) check("out_dout", out_dout, held[0]);
        if (exp_ov && oa) begin
            void'(held.pop_front());
            if (out_left == 0) begin
                ready--;
                out_left = sizes.pop_front() - 1;
            end else out_left--;
        end
        if (iv && exp_acc) begin
            held.push_back(src_q.pop_front());
            sz = src_sz.pop_front();
            if (sz > 0) begin
                ready++;
                sizes.push_back(sz);
            end
        end
    endtask

    task automatic drain(input int pv, input int pa, input int budget);
        int k = 0;
        while ((src_q.size() > 0 || held.size() > 0) && k < budget) begin
            step(pv, pa);
            k++;
        end
        check("drain_done", src_q.size() + held.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_accept = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        src_q.delete();
        src_sz.delete();
        held.delete();
        sizes.delete();
        ready = 0;
        out_left = 0;
    endtask

    initial begin
        logic [31:0] h;
        repeat (3) @(negedge clk);
        do_reset();
        #1;
        check("rst_in_accept", in_accept, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_pkt_ready", pkt_ready, 0);
        check("rst_len_err", len_err, 0);

        add_pkt(32'hAB000000);
        step(100, 0);
        step(0, 0);
        check("zero_len_hdr", out_dout, 32'hAB000000);
        drain(100, 100, 20);
        step(0, 0);
        check("zero_len_empty", pkt_ready, 0);

        add_pkt(32'h12340003);
        repeat (3) step(100, 0);
        repeat (10) step(0, 100);
        step(100, 0);
        step(0, 0);
        check("hold_released", out_valid, 1);
        drain(100, 100, 20);

        add_pkt(32'hC000001F);
        add_pkt(32'hC100001F);
        add_pkt(32'hC2000002);
        repeat (70) step(100, 0);
        check("full_ready", pkt_ready, 2);
        check("full_accept", in_accept, 0);
        step(100, 100);
        step(100, 0);
        drain(100, 100, 200);

        add_pkt(32'h55000000);
        step(100, 0);
        add_pkt(32'h66000002);
        step(100, 0);
        step(100, 0);
        step(100, 100);
        step(0, 0);
        check("coincident_ready", pkt_ready, 1);
        drain(100, 100, 20);

        for (int i = 0; i < 100; i++) begin
            h = ($urandom & 32'hFFFFFFE0) | 32'd5;
            add_pkt(h);
        end
        drain(100, 100, 2000);

        add_pkt(32'h0000000A);
        repeat (5) step(100, 0);
        do_reset();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_pkt_ready", pkt_ready, 0);
        check("midrst_in_accept", in_accept, 1);
        add_pkt(32'h7E000004);
        drain(100, 100, 50);

        for (int i = 0; i < 1000; i++) add_pkt($urandom);
        drain(70, 65, 60000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bluetile_packet_buffer.md
# bluetile_packet_buffer

Store-and-forward packet buffer between the GPIO processor's BlueTile client request stream and the BlueTile network injection port. It accepts 32-bit flits from the processor wrapper's request output, tracks packet boundaries from the header's length field, and forwards a packet downstream only once every flit of that packet is held. The network never sees a partially produced packet, so a stalled processor cannot block a network link mid-packet.

## Interface
- `DEPTH`, 64: buffer capacity in words. Must be a power of 2 and at least 33.
- `CLK` in 1: single clock; all state is updated on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `in_DIN` in 32: flit from the processor's `bluetile_client_request_DOUT`.
- `in_valid` in 1: flit valid, from `bluetile_client_request_valid`.
- `in_accept` out 1: the block takes `in_DIN` this cycle. Drives `bluetile_client_request_accept`.
- `out_DOUT` out 32: flit to the network.
- `out_valid` out 1: `out_DOUT` is valid.
- `out_accept` in 1: the network takes `out_DOUT` this cycle.
- `pkt_ready` out 6: number of complete packets held, saturating at 63.
- `len_err` out 1: sticky flag. Set when a header carries a length above 31, which is not possible with a 5-bit field; treat it as reserved. Cleared only by reset.

## Operation
- **Packet format**
  - Word 0 is the header; `hdr[4:0]` = N, the payload length (0..31).
  - N payload words follow, so a packet is N+1 words total.
  - All other header bits pass through untouched.
- **Storage:** circular word RAM of `DEPTH` entries.
  - Write pointer, read pointer and fill count are each log2(DEPTH)+1 bits wide.
  - Pointers wrap modulo `DEPTH`.
- **Input FSM**
  - States `IN_HDR` and `IN_PAY`.
  - `in_accept` = !full, independent of state.
  - Transfer occurs when `in_valid` && `in_accept`.
  - `IN_HDR` on transfer:
    - If N == 0: the packet is complete; increment `complete`.
    - Otherwise: load `in_rem` = N and go to `IN_PAY`.
  - `IN_PAY` on transfer:
    - Decrement `in_rem`.
    - When `in_rem` reaches 0, increment `complete` and return to `IN_HDR`.
- **Output FSM**
  - States `OUT_IDLE` and `OUT_PAY`.
  - `OUT_IDLE`: `out_valid` = (`complete` != 0); `out_DOUT` = RAM[rd].
    - On transfer, decrement `complete` and read N from the header.
    - If N == 0, stay in `OUT_IDLE`.
    - Otherwise, load `out_rem` = N and go to `OUT_PAY`.
  - `OUT_PAY`: `out_valid` = 1. Each transfer decrements `out_rem`; at 0, return to `OUT_IDLE`.
- **Deadlock freedom:** a partial packet occupies at most 32 words, which is less than `DEPTH`. Full is therefore only reachable while complete packets are held, and those drain independently of the input.
- **Simultaneous events**
  - Input completion and output header transfer in the same cycle leave `complete` unchanged.
  - Simultaneous push and pop leave the fill count unchanged.
  - A push is allowed when full only if… no: `in_accept` is based on registered full, so there is no push on a full buffer even if a pop occurs that cycle.
- **`pkt_ready`:** equals `complete`, saturating at 63 for display purposes. The internal counter is wide enough not to saturate, since at most `DEPTH` packets can be held.
- **Reset:** applies mid-packet with no drain.
  - Pointers, count and `complete` clear to 0.
  - Both FSMs return to `IN_HDR` / `OUT_IDLE`.
  - The partial packet is discarded; RAM contents are don't-care.

## Timing
- **Reset values:**
  - `in_accept` = 1 (buffer empty).
  - `out_valid` = 0.
  - `pkt_ready` = 0.
  - `len_err` = 0.
  - `out_DOUT` is don't-care while `out_valid` = 0.
- **Latency:** the final flit of a packet accepted in cycle t gives `out_valid` = 1 in cycle t+1 (registered `complete`). Header data is visible that same cycle.
- **Throughput:**
  - One flit per cycle on each side concurrently.
  - Back-to-back packets leave no gap on the output once complete.
- **Output stability:** `out_DOUT` and `out_valid` are held stable while `out_valid` && !`out_accept`.
- **Source and sink rules:**
  - The source may drop `in_valid` between flits; `in_accept` has no dependence on `in_valid`.
  - `out_accept` while `out_valid` = 0 has no effect.
- **RAM read:** either asynchronous, or registered with a lookahead read of the next address. The result must be identical at the ports.

## Structure
- **Shared package `bluetile_pkg`:**
  - `FLIT_W` = 32.
  - `LEN_LSB`/`LEN_MSB` = 0/4.
  - `MAX_PAYLOAD` = 31.
  - FSM state enums for both sides.
- **Sub-module `bluetile_word_ram`:** `DEPTH`×32 dual-port RAM, one write port and one read port. It is the only sub-module; FSMs and counters live in the top.

## Test plan
- **Single zero-length packet:** push header 0xAB000000 → one cycle later `out_valid` = 1 with `out_DOUT` = 0xAB000000; after pop, `pkt_ready` returns to 0.
- **Hold until complete:** push header N=3 and 2 payload words, then stall `in_valid` for 10 cycles → `out_valid` stays 0. Push the 3rd word → `out_valid` next cycle, and the 4 words emerge in order.
- **Fill to full:** push two 32-word packets (N=31) with `out_accept` = 0 → `in_accept` drops after 64 words and `pkt_ready` = 2. Assert `out_accept` → one word drains, then `in_accept` = 1.
- **Concurrent traffic:** input completes a packet in the same cycle the output takes a header → `complete` is unchanged. Random valid/accept patterns over 1000 packets → output stream equals input stream.
- **Pointer wrap:** send 100 packets of N=5 continuously → data is correct across several `DEPTH` wraps.
- **Reset mid-packet:** after header N=10 and 4 payload words, assert `RST` for 1 cycle → `out_valid` = 0, `pkt_ready` = 0, `in_accept` = 1. A new packet then passes through intact.
